ps2_event_queue: RTL

- Sits directly downstream of the PS/2 receiver.
- Brings the receiver's ps2_clk-domain strobes and 11-bit frame into the system clock domain and validates each frame (start, stop, odd parity).
- Folds the 0xE0 and 0xF0 prefix indications into a single key-event word.
- Buffers events in a FIFO that the CPU-side logic drains through a valid/ready handshake.

---
 rtl/ps2_event_queue.sv | 100 ++++++++++
 1 files changed

// File: rtl/ps2_event_queue.sv
// ps2_event_queue: synchronises PS/2 receiver strobes, validates frames, folds prefixes, queues key events
// Ports: clk/rst (async active-low); frame + four receiver strobes in; evt_data/evt_valid/evt_ready
// show-ahead event FIFO out with fifo_count; sticky kbd_reset/frame_err/overflow cleared by clr_status; irq.
module ps2_event_queue #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [10:0]           frame,
  input  logic                  data_latch,
  input  logic                  release_key,
  input  logic                  extended_code,
  input  logic                  reset_required,
  output logic [9:0]            evt_data,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  kbd_reset,
  output logic                  frame_err,
  output logic                  overflow,
  input  logic                  clr_status,
  output logic                  irq
);
  logic [3:0] strobe, sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, det;
  logic [1:0] warm_q, warm_d;
  logic [7:0] code;
  logic [9:0] wr_word;
  logic [9:0] mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic ext_pend_q, ext_pend_d, rel_pend_q, rel_pend_d;
  logic kbd_q, kbd_d, ferr_q, ferr_d, ovf_q, ovf_d, irq_q, irq_d;
  logic good, take, push, pop, full, wr_en;
  assign strobe = {reset_required, extended_code, release_key, data_latch};
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign evt_valid = fifo_count != '0;
  assign evt_data = evt_valid ? mem_q[rd_ptr_q[ADDR_WIDTH-1:0]] : '0;
  assign kbd_reset = kbd_q;
  assign frame_err = ferr_q;
  assign overflow = ovf_q;
  assign irq = irq_q;
  always_comb begin
    sync1_d = strobe;
    sync2_d = sync1_q;
    // until the synchroniser has refilled after reset, the edge history follows sync1 so a strobe
    // already high at reset release is seen as "high" rather than as a new rising edge
    prev_d = warm_q[1] ? sync2_q : sync1_q;
    warm_d = warm_q[1] ? warm_q : warm_q + 2'd1;
    det = sync2_q & ~prev_q;
    for (int i = 0; i < 8; i++) code[i] = frame[9-i];
    good = ~frame[10] & frame[0] & (^frame[9:1]);
    take = det[0] & ~det[3];
    push = take & good;
    pop = evt_valid & evt_ready;
    full = fifo_count == (ADDR_WIDTH+1)'(FIFO_DEPTH);
    wr_en = push & (~full | pop);
    wr_word = {ext_pend_q, rel_pend_q, code};
    wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(pop);
    // a prefix arriving with a code frame is kept for the next code
    ext_pend_d = det[3] ? 1'b0 : det[0] ? det[2] : ext_pend_q | det[2];
    rel_pend_d = det[3] ? 1'b0 : det[0] ? det[1] : rel_pend_q | det[1];
    kbd_d = (kbd_q & ~clr_status) | det[3];
    ferr_d = (ferr_q & ~clr_status) | (take & ~good);
    ovf_d = (ovf_q & ~clr_status) | (push & full & ~pop);
    irq_d = evt_valid | kbd_q | ferr_q | ovf_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q <= '0;
      warm_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ext_pend_q <= 1'b0;
      rel_pend_q <= 1'b0;
      kbd_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q <= prev_d;
      warm_q <= warm_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ext_pend_q <= ext_pend_d;
      rel_pend_q <= rel_pend_d;
      kbd_q <= kbd_d;
      ferr_q <= ferr_d;
      ovf_q <= ovf_d;
      irq_q <= irq_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_word;
  end
endmodule
